// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the mux select arbiter slice.
package mux_sel_pkg;

  localparam int unsigned N_CH  = 16;
  localparam int unsigned SEL_W = 4;

  typedef logic [SEL_W-1:0] ch_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot decode of a channel index.
  function automatic logic [N_CH-1:0] onehot(input ch_idx_t idx);
    logic [N_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/select/aligned-output bundle between the arbiter and its users.
interface mux_sel_arbiter_if;
  import mux_sel_pkg::*;

  logic [N_CH-1:0] req;
  logic            sel_ready;
  ch_idx_t         sel;
  logic            sel_valid;
  logic [N_CH-1:0] grant;
  logic            y_valid;
  ch_idx_t         y_ch;

  // Arbiter side.
  modport master (
    input  req, sel_ready,
    output sel, sel_valid, grant, y_valid, y_ch
  );

  // Requesters / consumer side.
  modport slave (
    output req, sel_ready,
    input  sel, sel_valid, grant, y_valid, y_ch
  );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or above start, wrapping.
module rr_pick
  import mux_sel_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  ch_idx_t         start,
  output logic            found,
  output ch_idx_t         idx
);

  ch_idx_t cand;

  // Walk the channels from start upward; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = start + ch_idx_t'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for the 16:1 registered output mux, with
// per-tenure beat limit and y_valid/y_ch aligned to the mux output register.
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 4
) (
  input logic              clk,
  input logic              rst,
  mux_sel_arbiter_if.master bus
);

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

  arb_state_t state_q, state_d;
  ch_idx_t    sel_q, sel_d;
  ch_idx_t    last_q, last_d;
  logic [7:0] beat_q, beat_d;

  ch_idx_t    start;
  ch_idx_t    pick;
  logic       found;
  logic       sel_valid;
  logic       accept;
  logic       tenure_end;

  logic       y_valid_q;
  ch_idx_t    y_ch_q;

  // In GRANT the search starts just past the owner, making it lowest priority.
  assign start = (state_q == GRANT) ? sel_q + ch_idx_t'(1) : last_q + ch_idx_t'(1);

  rr_pick u_pick (
    .req   (bus.req),
    .start (start),
    .found (found),
    .idx   (pick)
  );

  assign sel_valid  = (state_q == GRANT) && bus.req[sel_q];
  assign accept     = sel_valid && bus.sel_ready;
  assign tenure_end = (state_q == GRANT) &&
                      (!bus.req[sel_q] || (accept && (beat_q == LAST_BEAT)));

  // Next-state: grant on any request, re-arbitrate in the same edge a tenure ends.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = pick;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (tenure_end) begin
          last_d = sel_q;
          if (found) begin
            sel_d  = pick;
            beat_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          beat_d = beat_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state register; last resets to 15 so the first search begins at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= '1;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Track accepted beats one cycle later to line up with the mux output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid_q <= 1'b0;
      y_ch_q    <= '0;
    end else begin
      y_valid_q <= accept;
      if (accept) begin
        y_ch_q <= sel_q;
      end
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid;
  assign bus.grant     = (state_q == GRANT) ? onehot(sel_q) : '0;
  assign bus.y_valid   = y_valid_q;
  assign bus.y_ch      = y_ch_q;

endmodule
